// File: rtl/coproc_pkg.sv
// Shared types and widths for the coprocessor result queue.
// The entry layout follows the default interface widths of the queue.
package coproc_pkg;

  localparam int unsigned ID_W       = 4;
  localparam int unsigned RFW_W      = 32;
  localparam int unsigned XLEN_W     = 32;
  localparam int unsigned WE_W       = RFW_W / XLEN_W;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned EXCCODE_W  = 6;
  localparam int unsigned DROP_CNT_W = 8;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [RFW_W-1:0]     data;
    logic [RD_W-1:0]      rd;
    logic [WE_W-1:0]      we;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
  } result_entry_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    return (value == {DROP_CNT_W{1'b1}}) ? value : value + DROP_CNT_W'(1'b1);
  endfunction

endpackage

// File: rtl/coproc_fifo.sv
// Generic synchronous first-word-fall-through FIFO; rdata shows the head entry.
module coproc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == CNT_W'(1'b0));
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Storage array, written at the tail
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/coproc_result_queue.sv
// In-order result buffer between the coprocessor and the core's result interface;
// each result waits for a commit (forwarded) or kill (dropped) of its instruction ID.
module coproc_result_queue
  import coproc_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = ID_W,
  parameter int unsigned X_RFW_WIDTH = RFW_W,
  parameter int unsigned XLEN        = XLEN_W,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cp_valid,
  output logic                          cp_ready,
  input  logic [X_ID_WIDTH-1:0]         cp_id,
  input  logic [X_RFW_WIDTH-1:0]        cp_data,
  input  logic [4:0]                    cp_rd,
  input  logic [X_RFW_WIDTH/XLEN-1:0]   cp_we,
  input  logic                          cp_exc,
  input  logic [EXCCODE_W-1:0]          cp_exccode,
  input  logic                          commit_valid,
  input  logic [X_ID_WIDTH-1:0]         commit_id,
  input  logic                          commit_kill,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [X_ID_WIDTH-1:0]         result_id,
  output logic [X_RFW_WIDTH-1:0]        result_data,
  output logic [4:0]                    result_rd,
  output logic [X_RFW_WIDTH/XLEN-1:0]   result_we,
  output logic                          result_exc,
  output logic [EXCCODE_W-1:0]          result_exccode,
  output logic [5:0]                    result_ecsdata,
  output logic [2:0]                    result_ecswe,
  output logic                          result_err,
  output logic                          result_dbg,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;
  localparam int unsigned ENTRY_W = $bits(result_entry_t);

  result_entry_t               wentry_s;
  result_entry_t               head_s;
  logic [ENTRY_W-1:0]          head_raw_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        drop_s;
  logic                        load_s;
  logic                        slot_free_s;
  logic [NUM_IDS-1:0]          head_oh_s;
  logic [NUM_IDS-1:0]          commit_oh_s;
  logic [NUM_IDS-1:0]          clr_c_s;
  logic [NUM_IDS-1:0]          clr_k_s;
  logic [NUM_IDS-1:0]          set_c_s;
  logic [NUM_IDS-1:0]          set_k_s;
  logic [NUM_IDS-1:0]          committed_r;
  logic [NUM_IDS-1:0]          killed_r;
  result_entry_t               res_r;
  logic                        res_valid_r;
  logic [DROP_CNT_W-1:0]       drop_cnt_r;

  assign cp_ready = ~rst_i & ~fifo_full_s;
  assign push_s   = cp_valid & cp_ready;

  assign wentry_s.id      = cp_id;
  assign wentry_s.data    = cp_data;
  assign wentry_s.rd      = cp_rd;
  assign wentry_s.we      = cp_we;
  assign wentry_s.exc     = cp_exc;
  assign wentry_s.exccode = cp_exccode;

  coproc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_s),
    .wdata (wentry_s),
    .pop   (pop_s),
    .rdata (head_raw_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (occupancy)
  );

  assign head_s      = result_entry_t'(head_raw_s);
  assign slot_free_s = ~res_valid_r | result_ready;

  // Head decision: a kill wins over a commit, and only the head is ever examined
  always_comb begin
    drop_s = 1'b0;
    load_s = 1'b0;
    if (!fifo_empty_s) begin
      if (killed_r[head_s.id]) begin
        drop_s = 1'b1;
      end else if (committed_r[head_s.id] && slot_free_s) begin
        load_s = 1'b1;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  assign pop_s = drop_s | load_s;

  // Table masks; sets are OR-ed after clears so a reused ID keeps its new status
  always_comb begin
    head_oh_s   = NUM_IDS'(1'b1) << head_s.id;
    commit_oh_s = NUM_IDS'(1'b1) << commit_id;
    clr_c_s     = load_s ? head_oh_s : '0;
    clr_k_s     = drop_s ? head_oh_s : '0;
    set_c_s     = (commit_valid && !commit_kill) ? commit_oh_s : '0;
    set_k_s     = (commit_valid &&  commit_kill) ? commit_oh_s : '0;
  end

  // Commit and kill tables
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      committed_r <= '0;
      killed_r    <= '0;
    end else begin
      committed_r <= (committed_r & ~clr_c_s) | set_c_s;
      killed_r    <= (killed_r    & ~clr_k_s) | set_k_s;
    end
  end

  // Output register; fields only change when a new committed head is loaded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_r       <= '0;
      res_valid_r <= 1'b0;
    end else if (load_s) begin
      res_r       <= head_s;
      res_valid_r <= 1'b1;
    end else if (res_valid_r && result_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_r <= '0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign result_valid   = res_valid_r;
  assign result_id      = res_r.id;
  assign result_data    = res_r.data;
  assign result_rd      = res_r.rd;
  assign result_we      = res_r.we;
  assign result_exc     = res_r.exc;
  assign result_exccode = res_r.exccode;
  assign result_ecsdata = 6'd0;
  assign result_ecswe   = 3'd0;
  assign result_err     = 1'b0;
  assign result_dbg     = 1'b0;
  assign drop_cnt       = drop_cnt_r;

endmodule

// File: doc/coproc_result_queue.md
Name: coproc_result_queue

Overview:
- Sits directly downstream of the coprocessor and drives the core's eXtension result interface.
- Buffers coprocessor results in order and holds each one until the core commits or kills its instruction ID.
- Forwards committed results with a valid/ready handshake and silently drops killed ones.
- Keeps a saturating count of dropped results.

Parameters:
- X_ID_WIDTH, 4, instruction ID width; commit table has 2**X_ID_WIDTH entries.
- X_RFW_WIDTH, 32, result data width.
- XLEN, 32, register width; result_we is X_RFW_WIDTH/XLEN bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cp_valid  in  1  coprocessor result valid
- cp_ready  out  1  queue can accept a result
- cp_id  in  X_ID_WIDTH  result instruction ID
- cp_data  in  X_RFW_WIDTH  result data
- cp_rd  in  5  destination register
- cp_we  in  X_RFW_WIDTH/XLEN  write enable
- cp_exc  in  1  exception flag
- cp_exccode  in  6  exception code
- commit_valid  in  1  commit strobe from core
- commit_id  in  X_ID_WIDTH  committed/killed ID
- commit_kill  in  1  1 = kill, 0 = commit
- result_valid  out  1  result to core valid
- result_ready  in  1  core accepts result
- result_id  out  X_ID_WIDTH
- result_data  out  X_RFW_WIDTH
- result_rd  out  5
- result_we  out  X_RFW_WIDTH/XLEN
- result_exc  out  1
- result_exccode  out  6
- result_ecsdata  out  6  tied to 0
- result_ecswe  out  3  tied to 0
- result_err  out  1  tied to 0
- result_dbg  out  1  tied to 0
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level
- drop_cnt  out  8  saturating count of killed results dropped

Behaviour:
- Reset: rst_i high clears, asynchronously, all of the following:
  - FIFO pointers and count;
  - committed[] and killed[] tables;
  - output register;
  - drop_cnt.
  All outputs are 0 during reset, except cp_ready, which is 0 while rst_i is high and 1 in the first cycle after release.
- Reset mid-operation discards all entries and the output register without emitting anything.
- Push: cp_ready = (count != DEPTH), decoded from registers. Push occurs when cp_valid && cp_ready; the entry written is {id, data, rd, we, exc, exccode}.
- Full: there is no bypass. cp_ready is 0 when full even if a pop occurs in the same cycle.
- Commit table:
  - On commit_valid, set killed[commit_id] if commit_kill, else committed[commit_id].
  - Table updates take effect the next cycle; there is no same-cycle bypass.
  - The commit may arrive before or after the result is pushed.
- Head evaluation, each cycle, with the FIFO non-empty and h = head.id:
  - killed[h]: pop and discard the head; clear killed[h]; drop_cnt += 1, saturating at 255. The output register is unaffected. One drop per cycle.
  - committed[h] and output slot free (result_valid==0, or result_valid && result_ready): pop the head into the output register; set result_valid; clear committed[h].
  - Neither bit set: the head waits. Later entries never bypass the head.
- If a set from commit_valid and a clear from pop hit the same ID in the same cycle, the set wins, because the ID is being reused.
- Output register:
  - Fields remain stable while result_valid && !result_ready.
  - result_valid drops after a handshake unless a new committed head is loaded in the same cycle, which allows back-to-back transfers at one result per cycle.
- Latency: with the commit already recorded, a push in cycle t produces result_valid in cycle t+2.
- Pointers: wrap modulo DEPTH. occupancy equals count, with simultaneous push and pop leaving count unchanged.
- A push with cp_valid while full is stalled, never lost.

Decomposition:
- coproc_pkg holds:
  - the typedef for the result entry struct;
  - EXCCODE_W = 6;
  - DROP_CNT_W = 8.
- Sub-module coproc_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, using the same clock and reset. The commit table and output register stay in the top module.

Test Plan:
- Commit id 3 (kill=0), then push id 3 with data 0xDEADBEEF, rd 5 -> result_valid 2 cycles after the push, with result_id 3, data 0xDEADBEEF, rd 5, we 1; occupancy returns to 0.
- Push id 1, then kill id 1 -> no result_valid; drop_cnt becomes 1; occupancy 0; cp_ready stays 1.
- Push ids 2, 4, 6 with only 4 and 6 committed -> nothing emitted (head blocks). Commit 2 -> results emitted in order 2, 4, 6, back-to-back with result_ready held at 1.
- Hold result_ready at 0 with committed pushes until occupancy reaches DEPTH -> cp_ready 0, output fields stable. Release result_ready -> all entries drain with no loss.
- Kill 256 times -> drop_cnt saturates at 255.
- Assert rst_i mid-drain with 3 entries -> all outputs 0 at once; after release, occupancy 0 and an old commit does not release a new entry with the same id.
